// File: rtl/int_sequencer.sv
// Interrupt entry/return sequencer: drains, pushes PC/flags, loads vector; RTI pops flags/PC.
// Entry pc_load DRAIN_CYC+6 cycles after acceptance, RTI pc_load 4 cycles after pulse; stall/flush only defer entry.
module int_sequencer #(
  parameter int PC_W      = 32,
  parameter int ADDR_W    = 20,
  parameter int DRAIN_CYC = 3,
  parameter int VEC_ADDR  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              int_in,
  input  logic              rti_in,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [15:0]       flags_in,
  input  logic [ADDR_W-1:0] sp_in,
  input  logic [15:0]       mem_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              sp_dec,
  output logic              sp_inc,
  output logic              pc_load,
  output logic [PC_W-1:0]   new_pc,
  output logic              flags_load,
  output logic [15:0]       flags_out,
  output logic              freeze_fetch,
  output logic              int_flush,
  output logic              int_ack,
  output logic              busy
);

  localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [ADDR_W-1:0] VEC_HI_A = ADDR_W'(VEC_ADDR);
  localparam logic [ADDR_W-1:0] VEC_LO_A = ADDR_W'(VEC_ADDR + 1);

  typedef enum logic [3:0] {
    IDLE, DRAIN, PUSH_HI, PUSH_LO, PUSH_F, VEC_HI, VEC_LO, VEC_LD,
    POP_F, POP_LO, POP_HI, RET_LD
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              int_q;
  logic              pending;
  logic              accept;
  logic [PC_W-1:0]   pc_sv;
  logic [15:0]       flags_sv;
  logic [15:0]       hi_q;
  logic [15:0]       lo_q;
  logic [15:0]       flags_q;

  // Acceptance clears pending even if a new edge lands in the same cycle: it merges into this entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      int_q    <= 1'b0;
      pending  <= 1'b0;
      pc_sv    <= '0;
      flags_sv <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      flags_q  <= '0;
    end else begin
      state <= state_nx;
      int_q <= int_in;
      if (accept)
        pending <= 1'b0;
      else if (int_in && !int_q)
        pending <= 1'b1;
      if (accept) begin
        pc_sv    <= pc_in;
        flags_sv <= flags_in;
        cnt      <= CNT_W'(DRAIN_CYC - 1);
      end else if (state == DRAIN) begin
        cnt <= cnt - 1'b1;
      end
      // Read data trails mem_rd by one cycle, so each word is latched in the following state.
      case (state)
        VEC_LO: hi_q    <= mem_rdata;
        POP_LO: flags_q <= mem_rdata;
        POP_HI: lo_q    <= mem_rdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx     = state;
    accept       = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    sp_dec       = 1'b0;
    sp_inc       = 1'b0;
    pc_load      = 1'b0;
    new_pc       = '0;
    flags_load   = 1'b0;
    freeze_fetch = 1'b0;
    int_flush    = 1'b0;
    int_ack      = 1'b0;
    case (state)
      IDLE: begin
        if (rti_in) begin
          state_nx = POP_F;
        end else if (pending && !stall_in && !flush_in) begin
          accept   = 1'b1;
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        freeze_fetch = 1'b1;
        int_flush    = 1'b1;
        if (cnt == '0) state_nx = PUSH_HI;
      end
      PUSH_HI, PUSH_LO, PUSH_F: begin
        freeze_fetch = 1'b1;
        int_flush    = 1'b1;
        mem_wr       = 1'b1;
        mem_addr     = sp_in;
        sp_dec       = 1'b1;
        if (state == PUSH_HI) begin
          mem_wdata = 16'(pc_sv >> 16);
          state_nx  = PUSH_LO;
        end else if (state == PUSH_LO) begin
          mem_wdata = pc_sv[15:0];
          state_nx  = PUSH_F;
        end else begin
          mem_wdata = flags_sv;
          state_nx  = VEC_HI;
        end
      end
      VEC_HI: begin
        freeze_fetch = 1'b1;
        int_flush    = 1'b1;
        mem_rd       = 1'b1;
        mem_addr     = VEC_HI_A;
        state_nx     = VEC_LO;
      end
      VEC_LO: begin
        freeze_fetch = 1'b1;
        int_flush    = 1'b1;
        mem_rd       = 1'b1;
        mem_addr     = VEC_LO_A;
        state_nx     = VEC_LD;
      end
      VEC_LD: begin
        freeze_fetch = 1'b1;
        int_flush    = 1'b1;
        pc_load      = 1'b1;
        new_pc       = PC_W'({hi_q, mem_rdata});
        int_ack      = 1'b1;
        state_nx     = IDLE;
      end
      POP_F, POP_LO, POP_HI: begin
        freeze_fetch = 1'b1;
        mem_rd       = 1'b1;
        mem_addr     = sp_in + ADDR_W'(1);
        sp_inc       = 1'b1;
        if (state == POP_F)       state_nx = POP_LO;
        else if (state == POP_LO) state_nx = POP_HI;
        else                      state_nx = RET_LD;
      end
      RET_LD: begin
        freeze_fetch = 1'b1;
        int_flush    = 1'b1;
        flags_load   = 1'b1;
        pc_load      = 1'b1;
        new_pc       = PC_W'({mem_rdata, lo_q});
        state_nx     = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign flags_out = flags_q;

endmodule

// File: tb/tb_int_sequencer.sv
// Randomized scoreboard bench for int_sequencer with a stack/vector memory and SP model.
module tb_int_sequencer;
  localparam int D = 3;

  typedef struct { int cyc; logic [19:0] addr; logic [15:0] dat; logic pop; } acc_t;
  typedef struct { int cyc; logic [31:0] pc; logic fl; logic [15:0] flags; logic ack; } ld_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, int_in, rti_in, stall_in, flush_in;
  logic [31:0] pc_in;
  logic [15:0] flags_in;
  logic [19:0] sp;
  logic [15:0] mem_rdata;
  logic        mem_rd, mem_wr, sp_dec, sp_inc, pc_load, flags_load;
  logic [19:0] mem_addr;
  logic [15:0] mem_wdata, flags_out;
  logic [31:0] new_pc;
  logic        freeze_fetch, int_flush, int_ack, busy;

  logic        sp_force = 1'b0;
  logic [19:0] sp_force_val = '0;
  logic [15:0] mem [bit [19:0]];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  acc_t wr_q[$];
  acc_t rd_q[$];
  ld_t  ld_q[$];

  int_sequencer dut (
    .clk(clk), .rst(rst), .int_in(int_in), .rti_in(rti_in), .stall_in(stall_in),
    .flush_in(flush_in), .pc_in(pc_in), .flags_in(flags_in), .sp_in(sp),
    .mem_rdata(mem_rdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .sp_dec(sp_dec), .sp_inc(sp_inc), .pc_load(pc_load),
    .new_pc(new_pc), .flags_load(flags_load), .flags_out(flags_out),
    .freeze_fetch(freeze_fetch), .int_flush(int_flush), .int_ack(int_ack), .busy(busy)
  );

  function automatic logic [15:0] m(input logic [19:0] a);
    if (mem.exists(a)) return mem[a];
    return 16'h0;
  endfunction

  // Environment: memory with one-cycle read latency and the stack pointer register.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wr === 1'b1) mem[mem_addr] = mem_wdata;
    if (mem_rd === 1'b1) mem_rdata <= m(mem_addr);
    if (sp_force) sp <= sp_force_val;
    else sp <= sp - {19'b0, (sp_dec === 1'b1)} + {19'b0, (sp_inc === 1'b1)};
  end

  // Monitor: every strobe the DUT presents must match the next expected entry, cycle included.
  always @(negedge clk) begin
    acc_t e;
    ld_t  l;
    if (mem_wr === 1'b1) begin
      n_chk++;
      if (wr_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: cycle %0d addr %h data %h", cyc, mem_addr, mem_wdata);
      end else begin
        e = wr_q.pop_front();
        if (cyc != e.cyc || mem_addr !== e.addr || mem_wdata !== e.dat || sp_dec !== 1'b1 ||
            sp_inc !== 1'b0 || freeze_fetch !== 1'b1 || int_flush !== 1'b1 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL push: got cycle %0d addr %h data %h dec %b frz %b fl %b, expected cycle %0d addr %h data %h",
                   cyc, mem_addr, mem_wdata, sp_dec, freeze_fetch, int_flush, e.cyc, e.addr, e.dat);
        end
      end
    end
    if (mem_rd === 1'b1) begin
      n_chk++;
      if (rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read: cycle %0d addr %h", cyc, mem_addr);
      end else begin
        e = rd_q.pop_front();
        if (cyc != e.cyc || mem_addr !== e.addr || sp_inc !== e.pop || sp_dec !== 1'b0 ||
            int_flush !== !e.pop || freeze_fetch !== 1'b1 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL read: got cycle %0d addr %h inc %b fl %b frz %b, expected cycle %0d addr %h inc %b",
                   cyc, mem_addr, sp_inc, int_flush, freeze_fetch, e.cyc, e.addr, e.pop);
        end
      end
    end
    if (pc_load === 1'b1) begin
      n_chk++;
      if (ld_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pc_load: cycle %0d new_pc %h", cyc, new_pc);
      end else begin
        l = ld_q.pop_front();
        if (cyc != l.cyc || new_pc !== l.pc || int_ack !== l.ack || flags_load !== l.fl ||
            (l.fl && flags_out !== l.flags) || freeze_fetch !== 1'b1 || int_flush !== 1'b1) begin
          n_fail++;
          $display("FAIL pc_load: got cycle %0d pc %h ack %b fload %b flags %h, expected cycle %0d pc %h ack %b fload %b flags %h",
                   cyc, new_pc, int_ack, flags_load, flags_out, l.cyc, l.pc, l.ack, l.fl, l.flags);
        end
      end
    end
    if ((int_ack === 1'b1 || flags_load === 1'b1) && pc_load !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL ack_without_load: cycle %0d ack %b fload %b pc_load %b", cyc, int_ack, flags_load, pc_load);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_sp(input logic [19:0] s);
    sp_force     = 1'b1;
    sp_force_val = s;
    tick();
    sp_force = 1'b0;
  endtask

  // Entry accepted in cycle a: three pushes descending from s, two vector reads, then the jump.
  task automatic exp_isr(input int a, input logic [31:0] p, input logic [15:0] f, input logic [19:0] s);
    wr_q.push_back('{a + D + 1, s,                p[31:16], 1'b0});
    wr_q.push_back('{a + D + 2, 20'(s - 20'd1),   p[15:0],  1'b0});
    wr_q.push_back('{a + D + 3, 20'(s - 20'd2),   f,        1'b0});
    rd_q.push_back('{a + D + 4, 20'd2, 16'h0, 1'b0});
    rd_q.push_back('{a + D + 5, 20'd3, 16'h0, 1'b0});
    ld_q.push_back('{a + D + 6, {m(20'd2), m(20'd3)}, 1'b0, 16'h0, 1'b1});
  endtask

  // RTI pulse in cycle r with SP s: pops flags, low, high words from s+1 upward.
  task automatic exp_rti(input int r, input logic [19:0] s);
    for (int i = 1; i <= 3; i++) rd_q.push_back('{r + i, 20'(s + 20'(i)), 16'h0, 1'b1});
    ld_q.push_back('{r + 4, {m(20'(s + 20'd3)), m(20'(s + 20'd2))}, 1'b1, m(20'(s + 20'd1)), 1'b0});
  endtask

  task automatic run_isr(input logic [31:0] p, input logic [15:0] f, input logic [19:0] s,
                         input int ns, input bit use_flush);
    set_sp(s);
    int_in   = 1'b1;
    pc_in    = $urandom;
    flags_in = 16'($urandom);
    tick();
    int_in = 1'b0;
    repeat (ns) begin
      if (use_flush) flush_in = 1'b1;
      else stall_in = 1'b1;
      pc_in = $urandom;
      tick();
    end
    stall_in = 1'b0;
    flush_in = 1'b0;
    pc_in    = p;
    flags_in = f;
    exp_isr(cyc, p, f, s);
    tick();
    pc_in    = $urandom;
    flags_in = 16'($urandom);
  endtask

  task automatic run_rti();
    rti_in = 1'b1;
    exp_rti(cyc, sp);
    tick();
    rti_in = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    int t = 0;
    while ((wr_q.size() + rd_q.size() + ld_q.size()) != 0 && t < max) begin
      tick();
      t++;
    end
    n_chk++;
    if ((wr_q.size() + rd_q.size() + ld_q.size()) != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: cycle %0d pending wr %0d rd %0d ld %0d, expected all 0",
               cyc, wr_q.size(), rd_q.size(), ld_q.size());
      wr_q.delete();
      rd_q.delete();
      ld_q.delete();
    end
    tick();
  endtask

  function automatic logic [19:0] safe_sp();
    logic [19:0] s = 20'($urandom);
    if (s < 20'd8) s = s + 20'd8;
    if (s > 20'hFFFF0) s = s - 20'd16;
    return s;
  endfunction

  initial begin
    logic [31:0] p;
    logic [15:0] f;
    logic [19:0] s;
    int a;
    rst = 1'b0; int_in = 1'b0; rti_in = 1'b0; stall_in = 1'b0; flush_in = 1'b0;
    pc_in = '0; flags_in = '0; sp = '0; mem_rdata = '0;
    repeat (3) tick();
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_strobes", {25'b0, mem_rd, mem_wr, sp_dec, sp_inc, pc_load, flags_load, int_ack}, 32'h0);
    chk("rst_freeze_flush", {30'b0, freeze_fetch, int_flush}, 32'h0);
    chk("rst_new_pc", new_pc, 32'h0);
    chk("rst_flags_out", {16'h0, flags_out}, 32'h0);
    rst = 1'b1;
    tick();

    // Basic entry, then return from the stack it built.
    mem[20'd2] = 16'h0000;
    mem[20'd3] = 16'h0200;
    run_isr(32'h0000_1234, 16'h0005, 20'hFFFFF, 0, 1'b0);
    wait_drain(40);
    chk("t1_sp_after_push", {12'h0, sp}, 32'h000F_FFFC);
    chk("t1_stack_hi", {16'h0, m(20'hFFFFF)}, 32'h0000);
    chk("t1_stack_lo", {16'h0, m(20'hFFFFE)}, 32'h1234);
    chk("t1_stack_flags", {16'h0, m(20'hFFFFD)}, 32'h0005);
    run_rti();
    wait_drain(40);
    chk("t3_sp_after_pop", {12'h0, sp}, 32'h000F_FFFF);

    // Entry deferred by stall, then by flush.
    mem[20'd2] = 16'($urandom);
    mem[20'd3] = 16'($urandom);
    run_isr($urandom, 16'($urandom), 20'h40000, 2, 1'b0);
    wait_drain(40);
    run_rti();
    wait_drain(40);
    run_isr($urandom, 16'($urandom), safe_sp(), 2, 1'b1);
    wait_drain(40);

    // RTI and pending interrupt in the same cycle: RTI first.
    s = safe_sp();
    p = $urandom;
    f = 16'($urandom);
    set_sp(s);
    for (int i = 1; i <= 3; i++) mem[20'(s + 20'(i))] = 16'($urandom);
    pc_in = p; flags_in = f; int_in = 1'b1;
    tick();
    int_in = 1'b0;
    run_rti();
    exp_isr(cyc + 4, p, f, 20'(s + 20'd3));
    wait_drain(40);

    // Three extra edges while busy collapse into one further entry.
    s = safe_sp();
    p = $urandom;
    f = 16'($urandom);
    set_sp(s);
    pc_in = p; flags_in = f; int_in = 1'b1;
    tick();
    int_in = 1'b0;
    a = cyc;
    exp_isr(a, p, f, s);
    exp_isr(a + D + 7, p, f, 20'(s - 20'd3));
    for (int i = 0; i < 3; i++) begin
      tick();
      int_in = 1'b1;
      tick();
      int_in = 1'b0;
    end
    wait_drain(40);
    repeat (15) tick();

    // SP wrap on push and pop.
    run_isr($urandom, 16'($urandom), 20'h00001, 1, 1'b1);
    wait_drain(40);
    chk("wrap_sp", {12'h0, sp}, 32'h000F_FFFE);
    run_rti();
    wait_drain(40);

    for (int it = 0; it < 10; it++) begin
      mem[20'd2] = 16'($urandom);
      mem[20'd3] = 16'($urandom);
      run_isr($urandom, 16'($urandom), safe_sp(), int'($urandom_range(0, 3)), 1'(($urandom & 1)));
      wait_drain(40);
      repeat ($urandom_range(0, 2)) tick();
      run_rti();
      wait_drain(40);
    end

    // Reset during PUSH_LO with an interrupt pending: sequence and request both dropped.
    s = safe_sp();
    p = $urandom;
    set_sp(s);
    pc_in = p; int_in = 1'b1;
    tick();
    int_in = 1'b0;
    a = cyc;
    wr_q.push_back('{a + D + 1, s, p[31:16], 1'b0});
    wr_q.push_back('{a + D + 2, 20'(s - 20'd1), p[15:0], 1'b0});
    tick();
    int_in = 1'b1;
    tick();
    int_in = 1'b0;
    while (cyc < a + D + 2) tick();
    rst = 1'b0;
    tick();
    chk("rst_mid_busy", {31'b0, busy}, 32'h0);
    chk("rst_mid_strobes", {27'b0, mem_rd, mem_wr, sp_dec, sp_inc, pc_load}, 32'h0);
    chk("rst_mid_freeze_flush", {30'b0, freeze_fetch, int_flush}, 32'h0);
    rst = 1'b1;
    repeat (25) tick();
    wait_drain(5);
    chk("rst_mid_sp", {12'h0, sp}, {12'h0, 20'(s - 20'd2)});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: cycle %0d, expected completion earlier", cyc);
    $fatal(1, "watchdog");
  end

endmodule
